// File: rtl/pwm_capture_avalon.sv
// Avalon-MM slave that measures period and high time of several PWM inputs.
// Result words use the PWM generator packing {high[15:0], period[15:0]}.
module pwm_capture_avalon #(
  parameter int NUMBER_INPUTS = 4,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock_clk,
  input  logic                     reset_reset,
  input  logic [4:0]               s0_command_address,
  input  logic                     s0_command_read,
  input  logic                     s0_command_write,
  input  logic [31:0]              s0_command_writedata,
  output logic [31:0]              s0_command_readdata,
  input  logic [NUMBER_INPUTS-1:0] pwm_in,
  output logic                     irq
);

  localparam logic [4:0] ADDR_STATUS    = 5'd16;
  localparam logic [4:0] ADDR_PRESCALER = 5'd17;
  localparam logic [4:0] ADDR_IRQ_EN    = 5'd18;

  typedef enum logic {
    UNARMED = 1'b0,
    ARMED   = 1'b1
  } chan_state_t;

  logic [31:0]              prescaler;
  logic [31:0]              div_cnt;
  logic [NUMBER_INPUTS-1:0] irq_en;
  logic [NUMBER_INPUTS-1:0] valid;
  logic [NUMBER_INPUTS-1:0] overflow;
  logic [31:0]              result_word [NUMBER_INPUTS];
  logic                     tick;
  logic                     status_wr;
  logic                     prescaler_wr;
  logic                     irq_en_wr;
  logic [31:0]              rd_mux;

  assign tick         = (div_cnt == prescaler);
  assign status_wr    = s0_command_write && (s0_command_address == ADDR_STATUS);
  assign prescaler_wr = s0_command_write && (s0_command_address == ADDR_PRESCALER);
  assign irq_en_wr    = s0_command_write && (s0_command_address == ADDR_IRQ_EN);

  for (genvar i = 0; i < NUMBER_INPUTS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   level;
    logic                   rise;
    logic                   fall;
    chan_state_t            state;
    logic [15:0]            per_cnt;
    logic [15:0]            hi_cnt;
    logic [15:0]            hi_shadow;
    logic [15:0]            res_hi;
    logic [15:0]            res_per;
    logic                   valid_bit;
    logic                   ovf_bit;
    logic                   capture;
    logic                   ovf_set;
    logic                   rd_clr;
    logic                   ovf_clr;

    assign rd_clr         = s0_command_read && (s0_command_address == 5'(i));
    assign ovf_clr        = status_wr && s0_command_writedata[16+i];
    assign valid[i]       = valid_bit;
    assign overflow[i]    = ovf_bit;
    assign result_word[i] = {res_hi, res_per};

    // Synchroniser and edge detector; level stays aligned with the rise/fall pulses.
    always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
        sync  <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], pwm_in[i]};
        level <= sync[SYNC_STAGES-1];
        rise  <= sync[SYNC_STAGES-1] & ~level;
        fall  <= ~sync[SYNC_STAGES-1] & level;
      end
    end

    // A capture restarts the counters, so it takes priority over any wrap.
    always_comb begin
      capture = 1'b0;
      ovf_set = 1'b0;
      if (state == ARMED) begin
        capture = rise;
        ovf_set = !rise && tick &&
                  ((per_cnt == 16'hFFFF) || (level && (hi_cnt == 16'hFFFF)));
      end else begin
        capture = 1'b0;
        ovf_set = 1'b0;
      end
    end

    // Measurement FSM with counters, result, valid and overflow flags.
    always_ff @(posedge clock_clk) begin
      if (reset_reset) begin
        state     <= UNARMED;
        per_cnt   <= 16'd0;
        hi_cnt    <= 16'd0;
        hi_shadow <= 16'd0;
        res_hi    <= 16'd0;
        res_per   <= 16'd0;
        valid_bit <= 1'b0;
        ovf_bit   <= 1'b0;
      end else begin
        case (state)
          UNARMED: begin
            per_cnt <= 16'd0;
            hi_cnt  <= 16'd0;
            if (rise) begin
              state   <= ARMED;
              per_cnt <= {15'd0, tick};
              hi_cnt  <= {15'd0, tick};
            end
          end
          ARMED: begin
            if (capture) begin
              res_hi  <= hi_shadow;
              res_per <= per_cnt;
              per_cnt <= {15'd0, tick};
              hi_cnt  <= {15'd0, tick};
            end else if (ovf_set) begin
              state   <= UNARMED;
              per_cnt <= 16'd0;
              hi_cnt  <= 16'd0;
            end else begin
              if (tick) per_cnt <= per_cnt + 16'd1;
              if (tick && level) hi_cnt <= hi_cnt + 16'd1;
              if (fall) hi_shadow <= hi_cnt;
            end
          end
          default: state <= UNARMED;
        endcase
        if (capture) valid_bit <= 1'b1;
        else if (rd_clr) valid_bit <= 1'b0;
        if (ovf_set) ovf_bit <= 1'b1;
        else if (ovf_clr) ovf_bit <= 1'b0;
      end
    end
  end

  // Read-data multiplexer; unmapped addresses and channels above N read zero.
  always_comb begin
    rd_mux = 32'd0;
    case (s0_command_address)
      ADDR_STATUS:    rd_mux = {16'(overflow), 16'(valid)};
      ADDR_PRESCALER: rd_mux = prescaler;
      ADDR_IRQ_EN:    rd_mux = {16'd0, 16'(irq_en)};
      default: begin
        for (int k = 0; k < NUMBER_INPUTS; k++) begin
          rd_mux = rd_mux | ((s0_command_address == 5'(k)) ? result_word[k] : 32'd0);
        end
      end
    endcase
  end

  // Bus registers, tick divider and interrupt.
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      s0_command_readdata <= 32'd0;
      prescaler           <= 32'd0;
      div_cnt             <= 32'd0;
      irq_en              <= '0;
      irq                 <= 1'b0;
    end else begin
      if (s0_command_read) s0_command_readdata <= rd_mux;
      if (prescaler_wr) begin
        prescaler <= s0_command_writedata;
        div_cnt   <= 32'd0;
      end else if (tick) begin
        div_cnt <= 32'd0;
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end
      if (irq_en_wr) irq_en <= s0_command_writedata[NUMBER_INPUTS-1:0];
      irq <= |(valid & irq_en);
    end
  end

endmodule
